// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors judge and match tracker.
package rps_pkg;

  typedef enum logic [1:0] {
    ROCK     = 2'b00,
    PAPER    = 2'b01,
    SCISSORS = 2'b10
  } move_e;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    P1WIN = 2'b01,
    P2WIN = 2'b10,
    TIE   = 2'b11
  } result_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_WAIT_CLR = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_TALLY    = 3'd4,
    ST_DONE     = 3'd5
  } trk_state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/rps_sat_counter.sv
// Up-counter with synchronous clear; optionally holds at all-ones instead of wrapping.
module rps_sat_counter #(
  parameter int W   = 4,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;
  logic         w_full;

  assign w_full = SAT && (r_count == {W{1'b1}});

  // Count register: clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !w_full) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/rps_match_tracker.sv
// Match controller: starts rounds on the judge, captures verdicts after a
// ready 1->0->1 handshake, keeps scores and declares the match winner.
module rps_match_tracker
  import rps_pkg::*;
#(
  parameter int WINS_NEEDED = 2,
  parameter int SCORE_W     = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               next_round,
  input  logic               new_match,
  input  logic [1:0]         result,
  input  logic               ready,
  output logic               round_start,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [SCORE_W-1:0] ties,
  output logic               busy,
  output logic               match_over,
  output logic [1:0]         winner,
  output logic               timeout_err
);

  localparam int                 TMO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [SCORE_W-1:0] WIN_M1   = SCORE_W'(WINS_NEEDED - 1);

  trk_state_e       r_state;
  trk_state_e       w_state_nxt;
  logic [TMO_W-1:0] r_tmo;
  result_e          r_result;
  logic [1:0]       r_winner;
  logic             r_tmo_err;
  logic             r_round_start;
  logic             r_busy;
  logic             r_match_over;

  logic               w_tmo_hit;
  logic               w_p1_hit;
  logic               w_p2_hit;
  logic               w_inc_p1;
  logic               w_inc_p2;
  logic               w_inc_tie;
  logic [SCORE_W-1:0] w_p1;
  logic [SCORE_W-1:0] w_p2;
  logic [SCORE_W-1:0] w_ties;

  // A player wins when this tally lifts their score from WINS_NEEDED-1.
  assign w_p1_hit  = (r_result == P1WIN) && (w_p1 == WIN_M1);
  assign w_p2_hit  = (r_result == P2WIN) && (w_p2 == WIN_M1);
  assign w_inc_p1  = (r_state == ST_TALLY) && (r_result == P1WIN);
  assign w_inc_p2  = (r_state == ST_TALLY) && (r_result == P2WIN);
  assign w_inc_tie = (r_state == ST_TALLY) && (r_result == TIE);

  // Next-state decode; new_match overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_hit   = 1'b0;
    if (new_match) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     w_state_nxt = next_round ? ST_ARM : ST_IDLE;
        ST_ARM:      w_state_nxt = ST_WAIT_CLR;
        ST_WAIT_CLR: begin
          if (r_tmo == TMO_LAST) begin
            w_tmo_hit   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (!ready) begin
            w_state_nxt = ST_WAIT_RES;
          end else begin
            w_state_nxt = ST_WAIT_CLR;
          end
        end
        ST_WAIT_RES: begin
          if (r_tmo == TMO_LAST) begin
            w_tmo_hit   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (ready) begin
            w_state_nxt = ST_TALLY;
          end else begin
            w_state_nxt = ST_WAIT_RES;
          end
        end
        ST_TALLY:    w_state_nxt = (w_p1_hit || w_p2_hit) ? ST_DONE : ST_IDLE;
        ST_DONE:     w_state_nxt = ST_DONE;
        default:     w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, registered status outputs, timeout counter and verdict latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_tmo         <= '0;
      r_result      <= NONE;
      r_winner      <= WIN_NONE;
      r_tmo_err     <= 1'b0;
      r_round_start <= 1'b0;
      r_busy        <= 1'b0;
      r_match_over  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_round_start <= (w_state_nxt == ST_ARM);
      r_busy        <= (w_state_nxt == ST_ARM) || (w_state_nxt == ST_WAIT_CLR) ||
                       (w_state_nxt == ST_WAIT_RES);
      r_match_over  <= (w_state_nxt == ST_DONE);

      if ((r_state == ST_WAIT_CLR) || (r_state == ST_WAIT_RES)) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end else begin
        r_tmo <= '0;
      end

      if (w_state_nxt == ST_TALLY) begin
        r_result <= result_e'(result);
      end else begin
        r_result <= r_result;
      end

      if (new_match) begin
        r_winner  <= WIN_NONE;
        r_tmo_err <= 1'b0;
      end else begin
        if (w_tmo_hit) begin
          r_tmo_err <= 1'b1;
        end else begin
          r_tmo_err <= r_tmo_err;
        end
        if ((r_state == ST_TALLY) && w_p1_hit) begin
          r_winner <= WIN_P1;
        end else if ((r_state == ST_TALLY) && w_p2_hit) begin
          r_winner <= WIN_P2;
        end else begin
          r_winner <= r_winner;
        end
      end
    end
  end

  rps_sat_counter #(.W(SCORE_W), .SAT(1'b0)) u_p1_cnt (
    .clk(clk), .rst(rst), .clr(new_match), .inc(w_inc_p1), .count(w_p1)
  );

  rps_sat_counter #(.W(SCORE_W), .SAT(1'b0)) u_p2_cnt (
    .clk(clk), .rst(rst), .clr(new_match), .inc(w_inc_p2), .count(w_p2)
  );

  rps_sat_counter #(.W(SCORE_W), .SAT(1'b1)) u_tie_cnt (
    .clk(clk), .rst(rst), .clr(new_match), .inc(w_inc_tie), .count(w_ties)
  );

  assign round_start = r_round_start;
  assign p1_score    = w_p1;
  assign p2_score    = w_p2;
  assign ties        = w_ties;
  assign busy        = r_busy;
  assign match_over  = r_match_over;
  assign winner      = r_winner;
  assign timeout_err = r_tmo_err;

endmodule
